// File: rtl/mult_eval_pkg.sv
// Shared definitions for the multiplier evaluation blocks: sweep FSM states,
// default sweep size and the vector-index to operand mapping.
package mult_eval_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand width used by the reward flow and the resulting vector count.
    localparam int W_DEFAULT = 2;
    localparam int N         = 1 << (2 * W_DEFAULT);

    // Vector index i is laid out as {a, b}: a is the upper w bits.
    function automatic int unsigned vec_to_a(input int unsigned idx, input int unsigned w);
        return idx >> w;
    endfunction

    // The lower w bits of the vector index select operand b.
    function automatic int unsigned vec_to_b(input int unsigned idx, input int unsigned w);
        return idx & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/mult_golden.sv
// Exact unsigned W x W product, purely combinational. Used as the reference
// against which candidate multipliers are scored.
module mult_golden #(
    parameter int W = 2
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_p
);

    // Operands are widened first so the product is formed at full width.
    assign o_p = (2*W)'(i_a) * (2*W)'(i_b);

endmodule

// File: rtl/mult2_sweep_scorer.sv
// Exhaustive sweep scorer: drives every {a,b} pair into a combinational
// candidate multiplier, one per clock, and grades the returned product one
// cycle later against the exact product. Produces a match count, a per-vector
// failure mask and the lowest failing vector index.
module mult2_sweep_scorer
    import mult_eval_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [W-1:0]            cand_a,
    output logic [W-1:0]            cand_b,
    input  logic [2*W-1:0]          cand_p,
    output logic [2*W:0]            score,
    output logic [(1<<(2*W))-1:0]   err_mask,
    output logic [2*W-1:0]          first_err_idx,
    output logic                    first_err_valid
);

    localparam int IW = 2 * W;
    localparam int NV = 1 << IW;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_busy;
    logic            w_done;
    logic            w_accept;
    logic            w_compare;

    logic [IW-1:0]   r_idx;
    logic            r_last;
    logic [W-1:0]    r_cand_a;
    logic [W-1:0]    r_cand_b;
    logic [IW:0]     r_score;
    logic [NV-1:0]   r_err_mask;
    logic [IW-1:0]   r_first_err_idx;
    logic            r_first_err_valid;

    logic [IW-1:0]   w_idx_nxt;
    logic [IW-1:0]   w_vec;
    logic [IW-1:0]   w_exact;
    logic            w_match;

    // The vector being graded is the one currently presented to the candidate.
    assign w_vec     = {r_cand_a, r_cand_b};
    assign w_idx_nxt = r_idx + IW'(1);
    assign w_match   = (cand_p == w_exact);

    mult_golden #(
        .W (W)
    ) u_golden (
        .i_a (r_cand_a),
        .i_b (r_cand_b),
        .o_p (w_exact)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode; start is only honoured from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        w_compare   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_busy    = 1'b1;
                w_compare = 1'b1;
                if (r_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand drive and result accumulation; results persist until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx             <= '0;
            r_last            <= 1'b0;
            r_cand_a          <= '0;
            r_cand_b          <= '0;
            r_score           <= '0;
            r_err_mask        <= '0;
            r_first_err_idx   <= '0;
            r_first_err_valid <= 1'b0;
        end else if (w_accept) begin
            r_idx             <= '0;
            r_last            <= 1'b0;
            r_cand_a          <= '0;
            r_cand_b          <= '0;
            r_score           <= '0;
            r_err_mask        <= '0;
            r_first_err_idx   <= '0;
            r_first_err_valid <= 1'b0;
        end else if (w_compare) begin
            // Advance the driven vector until the last one, then hold it.
            if (!r_last) begin
                r_idx    <= w_idx_nxt;
                r_last   <= (w_idx_nxt == IW'(NV - 1));
                r_cand_a <= W'(vec_to_a(32'(w_idx_nxt), W));
                r_cand_b <= W'(vec_to_b(32'(w_idx_nxt), W));
            end
            // Grade the vector presented during the cycle just ending.
            if (w_match) begin
                r_score <= r_score + (IW+1)'(1);
            end else begin
                r_err_mask[w_vec] <= 1'b1;
                if (!r_first_err_valid) begin
                    r_first_err_idx   <= w_vec;
                    r_first_err_valid <= 1'b1;
                end
            end
        end
    end

    assign busy            = w_busy;
    assign done            = w_done;
    assign cand_a          = r_cand_a;
    assign cand_b          = r_cand_b;
    assign score           = r_score;
    assign err_mask        = r_err_mask;
    assign first_err_idx   = r_first_err_idx;
    assign first_err_valid = r_first_err_valid;

endmodule
